// File: rtl/dpfifo_pkg.sv
// dpfifo_pkg: shared sizing rules for dpfifo and its dpsram storage.
//   depth(aw) : number of entries addressed by an aw-bit pointer.
//   Pointers are aw bits wide and wrap naturally modulo depth; the
//   occupancy counter is aw+1 bits so it can hold 0..depth.
package dpfifo_pkg;
   function automatic int depth(input int aw);
      return 1 << aw;
   endfunction
endpackage

// File: rtl/dpsram.sv
// dpsram: dual-port storage array, no reset, gated by a clock enable.
//   clk_i, ena_i            : clock and global enable (low freezes everything)
//   adr_i/dat_i/wre_i/dat_o : port A, read/write, registered address
//   xadr_i/xdat_i/xwre_i/xdat_o : port X, read/write, registered address
// Reads are asynchronous from the registered address, so a write and an
// address update on the same edge make the new word visible right after it.
module dpsram
   import dpfifo_pkg::*;
#(
   parameter int AW = 5,
   parameter int DW = 2
) (
   input  logic          clk_i,
   input  logic          ena_i,
   input  logic [AW-1:0] adr_i,
   input  logic [DW-1:0] dat_i,
   input  logic          wre_i,
   output logic [DW-1:0] dat_o,
   input  logic [AW-1:0] xadr_i,
   input  logic [DW-1:0] xdat_i,
   input  logic          xwre_i,
   output logic [DW-1:0] xdat_o
);
   localparam int DEPTH = depth(AW);
   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] adr_q, xadr_q;
   always_ff @(posedge clk_i) begin
      if (ena_i) begin
         if (wre_i) mem[adr_i] <= dat_i;
         if (xwre_i) mem[xadr_i] <= xdat_i;
         adr_q <= adr_i;
         xadr_q <= xadr_i;
      end
   end
   assign dat_o = mem[adr_q];
   assign xdat_o = mem[xadr_q];
endmodule

// File: rtl/dpfifo.sv
// dpfifo: first-word-fall-through FIFO built on dpsram.
//   clk_i, rst_i (async, active-high), ena_i (global enable)
//   push_i/wdat_i : write side; full_o, afull_o (count >= AF)
//   pop_i/dat_o/vld_o : read side, dat_o is the head when vld_o=1
//   cnt_o : occupancy 0..DEPTH; err_o : sticky rejected push / empty pop
module dpfifo
   import dpfifo_pkg::*;
#(
   parameter int AW = 5,
   parameter int DW = 2,
   parameter int AF = (1 << AW) - 2
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          ena_i,
   input  logic          push_i,
   input  logic [DW-1:0] wdat_i,
   output logic          full_o,
   output logic          afull_o,
   input  logic          pop_i,
   output logic [DW-1:0] dat_o,
   output logic          vld_o,
   output logic [AW:0]   cnt_o,
   output logic          err_o
);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(depth(AW));
   localparam logic [AW:0] AF_CNT = (AW+1)'(AF);
   logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, xadr;
   logic [AW:0]   cnt_q, cnt_d;
   logic          err_q, err_d, push_ok, pop_ok;
   logic [DW-1:0] unused_adat;
   assign full_o = cnt_q == FULL_CNT;
   assign vld_o = cnt_q != '0;
   assign afull_o = cnt_q >= AF_CNT;
   assign cnt_o = cnt_q;
   assign err_o = err_q;
   always_comb begin
      push_ok = push_i & (~full_o | pop_i);
      pop_ok = pop_i & vld_o;
      // head address looks one ahead on a pop so the next entry falls through
      xadr = pop_ok ? rptr_q + 1'b1 : rptr_q;
      wptr_d = (ena_i & push_ok) ? wptr_q + 1'b1 : wptr_q;
      rptr_d = (ena_i & pop_ok) ? rptr_q + 1'b1 : rptr_q;
      cnt_d = ~ena_i ? cnt_q :
              (push_ok & ~pop_ok) ? cnt_q + 1'b1 :
              (pop_ok & ~push_ok) ? cnt_q - 1'b1 : cnt_q;
      err_d = err_q | (ena_i & ((push_i & full_o & ~pop_i) | (pop_i & ~vld_o)));
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end
   dpsram #(.AW(AW), .DW(DW)) u_ram (
      .clk_i  (clk_i),
      .ena_i  (ena_i),
      .adr_i  (wptr_q),
      .dat_i  (wdat_i),
      .wre_i  (push_ok),
      .dat_o  (unused_adat),
      .xadr_i (xadr),
      .xdat_i ('0),
      .xwre_i (1'b0),
      .xdat_o (dat_o)
   );
endmodule

// File: tb/tb_dpfifo.sv
// tb_dpfifo: randomized and directed checks of dpfifo against a queue model.
module tb_dpfifo;
   logic       clk_i = 1'b0, rst_i = 1'b1, ena_i = 1'b0, push_i = 1'b0, pop_i = 1'b0;
   logic [1:0] wdat_i = '0, dat_o;
   logic       full_o, afull_o, vld_o, err_o;
   logic [5:0] cnt_o;
   int         n_chk = 0, n_pass = 0;
   logic [1:0] q[$];
   bit         merr = 0;

   dpfifo dut (
      .clk_i(clk_i), .rst_i(rst_i), .ena_i(ena_i), .push_i(push_i), .wdat_i(wdat_i),
      .full_o(full_o), .afull_o(afull_o), .pop_i(pop_i), .dat_o(dat_o),
      .vld_o(vld_o), .cnt_o(cnt_o), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
   endtask

   task automatic verify();
      check("cnt", cnt_o, q.size());
      check("vld", vld_o, q.size() != 0);
      check("full", full_o, q.size() == 32);
      check("afull", afull_o, q.size() >= 30);
      check("err", err_o, merr);
      if (q.size() != 0) check("dat", dat_o, q[0]);
   endtask

   task automatic step(input logic ps, input logic pp, input logic [1:0] wd, input logic en);
      bit f, e;
      @(negedge clk_i);
      push_i = ps; pop_i = pp; wdat_i = wd; ena_i = en;
      @(posedge clk_i);
      if (en) begin
         f = q.size() == 32;
         e = q.size() == 0;
         if ((ps && f && !pp) || (pp && e)) merr = 1;
         if (pp && !e) void'(q.pop_front());
         if (ps && (!f || pp)) q.push_back(wd);
      end
      #1 verify();
   endtask

   // asynchronous reset, checked before any further clock edge
   task automatic do_reset();
      rst_i = 1'b1;
      push_i = 0; pop_i = 0; ena_i = 1;
      q.delete();
      merr = 0;
      #1;
      check("rst_cnt", cnt_o, 0);
      check("rst_vld", vld_o, 0);
      check("rst_full", full_o, 0);
      check("rst_afull", afull_o, 0);
      check("rst_err", err_o, 0);
      @(negedge clk_i);
      rst_i = 1'b0;
   endtask

   initial begin
      logic [5:0] c;
      logic [1:0] d;
      do_reset();
      step(1, 0, 2'h1, 1);
      check("first_dat", dat_o, 2'h1);
      step(0, 1, 0, 1);
      for (int i = 0; i < 32; i++) step(1, 0, 2'(i % 4), 1);
      check("filled", full_o, 1);
      step(1, 1, 2'h3, 1);
      check("sim_full_cnt", cnt_o, 32);
      check("sim_full_err", err_o, 0);
      for (int i = 0; i < 31; i++) step(0, 1, 0, 1);
      check("last_is_3", dat_o, 2'h3);
      step(0, 1, 0, 1);
      check("drained", vld_o, 0);
      for (int i = 0; i < 32; i++) step(1, 0, 2'(i % 4), 1);
      step(1, 0, 2'h2, 1);
      check("push_full_err", err_o, 1);
      for (int i = 0; i < 32; i++) step(0, 1, 0, 1);
      do_reset();
      step(1, 1, 2'h2, 1);
      check("pop_empty_err", err_o, 1);
      check("pop_empty_cnt", cnt_o, 1);
      check("pop_empty_dat", dat_o, 2'h2);
      do_reset();
      for (int i = 0; i < 7; i++) step(1, 0, 2'($urandom), 1);
      c = cnt_o;
      d = dat_o;
      for (int i = 0; i < 5; i++) begin
         step(i[0], ~i[0], 2'($urandom), 0);
         check("stall_cnt", cnt_o, c);
         check("stall_dat", dat_o, d);
      end
      check("pre_rst_cnt", cnt_o, 7);
      do_reset();
      for (int i = 0; i < 800; i++)
         step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45,
              2'($urandom), $urandom_range(0, 9) != 0);
      for (int i = 0; i < 300; i++)
         step($urandom_range(0, 99) < 80, $urandom_range(0, 99) < 75,
              2'($urandom), 1);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
